// File: rtl/hs32_decode_pkg.sv
// hs32_decode_pkg: opcode map, ALU ops, control bits and exec bundle type for hs32 decode
package hs32_decode_pkg;
  typedef enum logic [3:0] {
    HS32A_ADD    = 4'h0,
    HS32A_ADC    = 4'h1,
    HS32A_SUB    = 4'h2,
    HS32A_SBC    = 4'h3,
    HS32A_AND    = 4'h4,
    HS32A_BIC    = 4'h5,
    HS32A_OR     = 4'h6,
    HS32A_XOR    = 4'h7,
    HS32A_MOV    = 4'h8,
    HS32A_REVMOV = 4'h9
  } hs32_aluop_e;
  localparam logic [15:0] CTL_WB     = 16'h0001;
  localparam logic [15:0] CTL_IMM    = 16'h0002;
  localparam logic [15:0] CTL_MEMR   = 16'h0004;
  localparam logic [15:0] CTL_MEMW   = 16'h0008;
  localparam logic [15:0] CTL_FLAGS  = 16'h0010;
  localparam logic [15:0] CTL_BRANCH = 16'h0020;
  localparam logic [15:0] CTL_SHIFT  = 16'h0040;
  localparam logic [7:0] OP_LDR_I = 8'h10;
  localparam logic [7:0] OP_LDR_R = 8'h14;
  localparam logic [7:0] OP_MOV_R = 8'h20;
  localparam logic [7:0] OP_MOV_I = 8'h24;
  localparam logic [7:0] OP_STR_I = 8'h30;
  localparam logic [7:0] OP_STR_R = 8'h34;
  localparam logic [7:0] OP_B     = 8'h50;
  localparam logic [7:0] OP_CMP_R = 8'h60;
  localparam logic [7:0] OP_CMP_I = 8'h68;
  typedef struct packed {
    logic        fault;
    logic [3:0]  aluop;
    logic [4:0]  shift;
    logic [15:0] imm;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rn;
    logic [15:0] ctlsig;
    logic [1:0]  bank;
  } hs32_bundle_t;
endpackage

// File: rtl/hs32_decode_table.sv
// hs32_dec_table: combinational opcode ROM, opcode -> {aluop, ctlsig, legal}
module hs32_dec_table
  import hs32_decode_pkg::*;
(
  input  logic [7:0]  opcode,
  output logic [3:0]  aluop,
  output logic [15:0] ctlsig,
  output logic        legal
);
  // Illegal opcodes fall to REVMOV with no side effects so exec can trap in order
  always_comb begin
    aluop = HS32A_REVMOV;
    ctlsig = '0;
    legal = 1'b1;
    case (opcode) inside
      OP_LDR_I: begin aluop = HS32A_ADD; ctlsig = CTL_WB | CTL_IMM | CTL_MEMR; end
      OP_LDR_R: begin aluop = HS32A_ADD; ctlsig = CTL_WB | CTL_SHIFT | CTL_MEMR; end
      OP_MOV_R: begin aluop = HS32A_MOV; ctlsig = CTL_WB | CTL_SHIFT; end
      OP_MOV_I: begin aluop = HS32A_MOV; ctlsig = CTL_WB | CTL_IMM; end
      OP_STR_I: begin aluop = HS32A_ADD; ctlsig = CTL_IMM | CTL_MEMW; end
      OP_STR_R: begin aluop = HS32A_ADD; ctlsig = CTL_SHIFT | CTL_MEMW; end
      [8'h40:8'h47]: begin aluop = {1'b0, opcode[2:0]}; ctlsig = CTL_WB | CTL_FLAGS | CTL_SHIFT; end
      [8'h48:8'h4F]: begin aluop = {1'b0, opcode[2:0]}; ctlsig = CTL_WB | CTL_FLAGS | CTL_IMM; end
      OP_B:     begin aluop = HS32A_ADD; ctlsig = CTL_BRANCH | CTL_IMM; end
      OP_CMP_R: begin aluop = HS32A_SUB; ctlsig = CTL_FLAGS | CTL_SHIFT; end
      OP_CMP_I: begin aluop = HS32A_SUB; ctlsig = CTL_FLAGS | CTL_IMM; end
      default:  legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/hs32_decode.sv
// hs32_decode: fetch->exec decode stage with req/rdy handshakes; HS32_DEC_SKID_EN selects a 2-entry skid buffer
module hs32_decode
  import hs32_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        reqd,
  output logic        rdyd,
  input  logic [31:0] instd,
  output logic        reqe,
  input  logic        rdye,
  output logic [3:0]  aluop,
  output logic [4:0]  shift,
  output logic [15:0] imm,
  output logic [3:0]  rd,
  output logic [3:0]  rm,
  output logic [3:0]  rn,
  output logic [15:0] ctlsig,
  output logic [1:0]  bank,
  output logic        fault
);
  logic [3:0]   w_aluop;
  logic [15:0]  w_ctlsig;
  logic         w_legal;
  logic         w_take;
  hs32_bundle_t w_new;
  hs32_bundle_t r_out;
  logic         r_valid;
  hs32_dec_table u_table (
    .opcode (instd[31:24]),
    .aluop  (w_aluop),
    .ctlsig (w_ctlsig),
    .legal  (w_legal)
  );
  // Split the incoming word into the exec bundle; illegal words carry the fault flag
  always_comb begin
    w_new = '{fault: !w_legal, aluop: w_aluop, shift: instd[11:7], imm: instd[15:0],
              rd: instd[23:20], rm: instd[19:16], rn: instd[15:12], ctlsig: w_ctlsig, bank: instd[6:5]};
  end
`ifdef HS32_DEC_SKID_EN
  hs32_bundle_t r_skid;
  logic         r_skid_valid;
  logic         r_rdy;
  logic         w_free;
  logic         w_skid_nxt;
  assign rdyd = r_rdy && !flush;
  assign w_take = reqd && rdyd;
  assign w_free = !r_valid || rdye;
  assign w_skid_nxt = w_free ? (r_skid_valid && w_take) : (r_skid_valid || w_take);
  // Output slot refills from the skid entry first so bundle order is preserved; rdyd is registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_rdy <= 1'b0;
      r_out <= '0;
      r_skid <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_rdy <= 1'b1;
    end else begin
      r_valid <= r_skid_valid || w_take || (r_valid && !rdye);
      r_out <= !w_free ? r_out : r_skid_valid ? r_skid : w_take ? w_new : r_out;
      r_skid_valid <= w_skid_nxt;
      r_skid <= (w_take && !w_free) ? w_new : r_skid;
      r_rdy <= !w_skid_nxt;
    end
  end
`else
  assign rdyd = reset && !flush && (!r_valid || rdye);
  assign w_take = reqd && rdyd;
  // Single output register; a new word may replace the one exec takes this cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_out <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_take || (r_valid && !rdye);
      r_out <= w_take ? w_new : r_out;
    end
  end
`endif
  assign reqe   = r_valid;
  assign fault  = r_out.fault;
  assign aluop  = r_out.aluop;
  assign shift  = r_out.shift;
  assign imm    = r_out.imm;
  assign rd     = r_out.rd;
  assign rm     = r_out.rm;
  assign rn     = r_out.rn;
  assign ctlsig = r_out.ctlsig;
  assign bank   = r_out.bank;
endmodule

// File: tb/tb_hs32_decode.sv
// tb_hs32_decode: randomized scoreboard bench for hs32_decode against a rule-level decode model
module tb_hs32_decode;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        reqd = 1'b0;
  logic        rdyd;
  logic [31:0] instd = '0;
  logic        reqe;
  logic        rdye = 1'b0;
  logic [3:0]  aluop;
  logic [4:0]  shift;
  logic [15:0] imm;
  logic [3:0]  rd;
  logic [3:0]  rm;
  logic [3:0]  rn;
  logic [15:0] ctlsig;
  logic [1:0]  bank;
  logic        fault;
  logic [55:0] sb_q[$];
  int cmp = 0;
  int err = 0;
  int npop = 0;
  logic acc;
  localparam logic [15:0] WB = 16'h0001, IM = 16'h0002, MR = 16'h0004, MW = 16'h0008;
  localparam logic [15:0] FL = 16'h0010, BR = 16'h0020, SH = 16'h0040;
  hs32_decode dut (
    .clk(clk), .reset(reset), .flush(flush), .reqd(reqd), .rdyd(rdyd), .instd(instd),
    .reqe(reqe), .rdye(rdye), .aluop(aluop), .shift(shift), .imm(imm), .rd(rd), .rm(rm),
    .rn(rn), .ctlsig(ctlsig), .bank(bank), .fault(fault)
  );
  always #5 clk = ~clk;
  wire [55:0] out_vec = {fault, aluop, shift, imm, rd, rm, rn, ctlsig, bank};
  function automatic logic [55:0] model(input logic [31:0] w);
    logic [7:0] o;
    logic [3:0] a;
    logic [15:0] c;
    logic f;
    o = w[31:24];
    f = 1'b0;
    a = 4'd9;
    c = 16'h0;
    if (o == 8'h20) begin a = 4'd8; c = WB | SH; end
    else if (o == 8'h24) begin a = 4'd8; c = WB | IM; end
    else if (o == 8'h10) begin a = 4'd0; c = WB | IM | MR; end
    else if (o == 8'h14) begin a = 4'd0; c = WB | SH | MR; end
    else if (o == 8'h30) begin a = 4'd0; c = IM | MW; end
    else if (o == 8'h34) begin a = 4'd0; c = SH | MW; end
    else if (o[7:4] == 4'h4) begin a = {1'b0, o[2:0]}; c = WB | FL | (o[3] ? IM : SH); end
    else if (o == 8'h50) begin a = 4'd0; c = BR | IM; end
    else if (o == 8'h60 || o == 8'h68) begin a = 4'd2; c = FL | (o[3] ? IM : SH); end
    else f = 1'b1;
    return {f, a, w[11:7], w[15:0], w[23:20], w[19:16], w[15:12], c, w[6:5]};
  endfunction
  function automatic logic [31:0] rand_word();
    logic [7:0] lut [15];
    logic [7:0] op;
    lut = '{8'h10, 8'h14, 8'h20, 8'h24, 8'h30, 8'h34, 8'h40, 8'h43, 8'h47, 8'h48, 8'h4C, 8'h4F, 8'h50, 8'h60, 8'h68};
    op = ($urandom_range(0, 9) < 6) ? lut[$urandom_range(0, 14)] : 8'($urandom);
    return {op, 24'($urandom)};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Producer side: every accepted, non-squashed word pushes its expected bundle
  task automatic step();
    @(negedge clk);
    acc = reqd && rdyd;
    if (acc && reset && !flush) sb_q.push_back(model(instd));
    @(posedge clk);
    #1;
  endtask
  // Consumer side: pop on every exec transfer, check hold stability under backpressure
  initial begin
    logic        stall = 1'b0;
    logic [55:0] prev = '0;
    forever begin
      @(negedge clk);
      if (!reset || flush) begin
        sb_q.delete();
        stall = 1'b0;
      end else begin
        if (reqe && stall) chk("hold_stable", 64'(out_vec), 64'(prev));
        if (reqe && rdye) begin
          npop++;
          if (sb_q.size() == 0) begin
            cmp++;
            err++;
            $display("FAIL unexpected_bundle: got %h expected none", out_vec);
          end else chk("bundle", 64'(out_vec), 64'(sb_q.pop_front()));
        end
        stall = reqe && !rdye;
        prev = out_vec;
      end
    end
  end
  initial begin
    int n;
    int p0;
    reqd = 1'b1;
    instd = rand_word();
    repeat (2) step();
    chk("rst_reqe", 64'(reqe), 64'd0);
    chk("rst_rdyd", 64'(rdyd), 64'd0);
    chk("rst_outputs", 64'(out_vec), 64'd0);
    reset = 1'b1;
    reqd = 1'b0;
    step();
    chk("rdyd_after_release", 64'(rdyd), 64'd1);
    rdye = 1'b1;
    reqd = 1'b1;
    instd = 32'h24E1_0A45;
    step();
    chk("mov_reqe", 64'(reqe), 64'd1);
    chk("mov_fields", 64'({rd, rm, rn, imm, shift, bank, fault}), 64'({4'hE, 4'h1, 4'h0, 16'h0A45, 5'h14, 2'd2, 1'b0}));
    chk("mov_aluop", 64'(aluop), 64'd8);
    reqd = 1'b0;
    step();
    p0 = npop;
    reqd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instd = rand_word();
      step();
      chk("stream_accept", 64'(acc), 64'd1);
      chk("stream_reqe", 64'(reqe), 64'd1);
    end
    reqd = 1'b0;
    step();
    chk("stream_count", 64'(npop - p0), 64'd8);
    rdye = 1'b0;
    reqd = 1'b1;
    instd = rand_word();
    n = 0;
    repeat (3) begin
      step();
      if (acc) begin
        n++;
        instd = rand_word();
      end
    end
`ifdef HS32_DEC_SKID_EN
    chk("bp_taken", 64'(n), 64'd2);
`else
    chk("bp_taken", 64'(n), 64'd1);
`endif
    chk("bp_rdyd", 64'(rdyd), 64'd0);
    reqd = 1'b0;
    rdye = 1'b1;
    repeat (3) step();
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
    rdye = 1'b0;
    reqd = 1'b1;
    instd = rand_word();
    step();
    flush = 1'b1;
    instd = 32'h24DE_ADBE;
    #1;
    chk("flush_rdyd", 64'(rdyd), 64'd0);
    step();
    flush = 1'b0;
    reqd = 1'b0;
    chk("flush_reqe", 64'(reqe), 64'd0);
    rdye = 1'b1;
    repeat (2) step();
    chk("flush_quiet", 64'(reqe), 64'd0);
    reqd = 1'b1;
    instd = 32'hFF12_3456;
    step();
    chk("illegal_fault", 64'({fault, ctlsig, aluop}), 64'({1'b1, 16'h0, 4'd9}));
    instd = 32'h4012_3456;
    step();
    chk("legal_after_fault", 64'(fault), 64'd0);
    reqd = 1'b0;
    step();
    for (int i = 0; i < 600; i++) begin
      if (!reqd || acc || flush || !reset) begin
        reqd = $urandom_range(0, 3) != 0;
        instd = rand_word();
      end
      rdye = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 24) == 0;
      reset = $urandom_range(0, 79) != 0;
      step();
    end
    reset = 1'b1;
    flush = 1'b0;
    reqd = 1'b0;
    rdye = 1'b1;
    repeat (4) step();
    chk("final_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
